// File: rtl/vga_scan_pkg.sv
// vga_scan_pkg: VGA timing defaults, scanout FSM states and trace colours shared by the
// waveform display reader.
package vga_scan_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;
    localparam int SPLIT_Y_DEF  = 240;

    localparam int H_TOTAL = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    localparam logic [2:0] C_TRACE1_DEF = 3'b111;
    localparam logic [2:0] C_TRACE2_DEF = 3'b010;
    localparam logic [2:0] C_SPLIT_DEF  = 3'b001;

    typedef enum logic [1:0] {SCAN, GRANT, RESUME} scan_state_t;

    function automatic int line_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster counters, raw active-low syncs, visible flag and a frame_start
// pulse that is high while the counters sit at h=0, v=0.
module vga_timing_gen
    import vga_scan_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF
) (
    input  logic       clk,
    input  logic       rst,
    output logic [9:0] h,
    output logic [9:0] v,
    output logic       h_sync_raw,
    output logic       v_sync_raw,
    output logic       visible,
    output logic       frame_start
);

    localparam logic [9:0] H_LAST = 10'(line_total(H_ACTIVE, H_FP, H_SYNC, H_BP) - 1);
    localparam logic [9:0] V_LAST = 10'(line_total(V_ACTIVE, V_FP, V_SYNC, V_BP) - 1);
    localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);
    localparam logic [9:0] HS_ON  = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_OFF = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_ON  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_OFF = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic run;
    logic h_wrap;
    logic v_wrap;

    assign h_wrap     = h == H_LAST;
    assign v_wrap     = v == V_LAST;
    assign h_sync_raw = !(h >= HS_ON && h < HS_OFF);
    assign v_sync_raw = !(v >= VS_ON && v < VS_OFF);
    assign visible    = run && h < H_VIS && v < V_VIS;

    // The first clock after reset parks at (0,0) so frame_start can mark the opening pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h           <= '0;
            v           <= '0;
            run         <= 1'b0;
            frame_start <= 1'b0;
        end else if (!run) begin
            run         <= 1'b1;
            frame_start <= 1'b1;
        end else begin
            h           <= h_wrap ? '0 : h + 10'd1;
            v           <= h_wrap ? (v_wrap ? '0 : v + 10'd1) : v;
            frame_start <= h_wrap && v_wrap;
        end
    end

endmodule

// File: rtl/waveform_scanout.sv
// waveform_scanout: VGA reader for the time-domain and FFT waveform RAMs, drawing each as a
// connected trace and lending both RAMs to the writer only during vertical blanking.
module waveform_scanout
    import vga_scan_pkg::*;
#(
    parameter int         H_ACTIVE = H_ACTIVE_DEF,
    parameter int         H_FP     = H_FP_DEF,
    parameter int         H_SYNC   = H_SYNC_DEF,
    parameter int         H_BP     = H_BP_DEF,
    parameter int         V_ACTIVE = V_ACTIVE_DEF,
    parameter int         V_FP     = V_FP_DEF,
    parameter int         V_SYNC   = V_SYNC_DEF,
    parameter int         V_BP     = V_BP_DEF,
    parameter int         SPLIT_Y  = SPLIT_Y_DEF,
    parameter int         DATA_W   = 9,
    parameter int         ADDR_W   = 10,
    parameter logic [2:0] C_TRACE1 = C_TRACE1_DEF,
    parameter logic [2:0] C_TRACE2 = C_TRACE2_DEF,
    parameter logic [2:0] C_SPLIT  = C_SPLIT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_req,
    output logic              wr_grant,
    output logic [ADDR_W-1:0] ram1_addr,
    output logic [ADDR_W-1:0] ram2_addr,
    input  logic [DATA_W-1:0] ram1_data,
    input  logic [DATA_W-1:0] ram2_data,
    output logic              h_sync,
    output logic              v_sync,
    output logic              video_on,
    output logic [9:0]        pixel_x,
    output logic [9:0]        pixel_y,
    output logic              frame_start,
    output logic [2:0]        rgb
);

    localparam logic [9:0] H_VIS = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS = 10'(V_ACTIVE);
    localparam logic [9:0] SPLIT = 10'(SPLIT_Y);

    logic [9:0]  h, v;
    logic        hs0, vs0, vis0, en0;
    scan_state_t state;

    vga_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_timing (
        .clk(clk),
        .rst(rst),
        .h(h),
        .v(v),
        .h_sync_raw(hs0),
        .v_sync_raw(vs0),
        .visible(vis0),
        .frame_start(frame_start)
    );

    // A resumed frame draws from its very first pixel, the clock RESUME hands back to SCAN.
    assign en0       = state == SCAN || (state == RESUME && frame_start);
    assign ram1_addr = (state != GRANT && h < H_VIS) ? ADDR_W'(h) : '0;
    assign ram2_addr = ram1_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= SCAN;
            wr_grant <= 1'b0;
        end else begin
            case (state)
                SCAN: if (wr_req && h == '0 && v == V_VIS) begin
                    state    <= GRANT;
                    wr_grant <= 1'b1;
                end
                GRANT: if (!wr_req) begin
                    state    <= RESUME;
                    wr_grant <= 1'b0;
                end
                default: if (frame_start) state <= SCAN;
            endcase
        end
    end

    logic [9:0] x1, y1, prev1, prev2;
    logic       hs1, vs1, vis1, en1;
    logic [9:0] c1, c2, p1, p2, lo1, hi1, lo2, hi2;
    logic [2:0] colour;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x1   <= '0;
            y1   <= '0;
            hs1  <= 1'b1;
            vs1  <= 1'b1;
            vis1 <= 1'b0;
            en1  <= 1'b0;
        end else begin
            x1   <= h;
            y1   <= v;
            hs1  <= hs0;
            vs1  <= vs0;
            vis1 <= vis0;
            en1  <= en0;
        end
    end

    // Column 0 has no left neighbour, so its segment collapses to the sample itself.
    always_comb begin
        c1     = 10'(ram1_data);
        c2     = 10'(ram2_data);
        p1     = x1 == '0 ? c1 : prev1;
        p2     = x1 == '0 ? c2 : prev2;
        lo1    = p1 < c1 ? p1 : c1;
        hi1    = p1 < c1 ? c1 : p1;
        lo2    = p2 < c2 ? p2 : c2;
        hi2    = p2 < c2 ? c2 : p2;
        colour = y1 == SPLIT ? C_SPLIT
               : (en1 && y1 < SPLIT && y1 >= lo1 && y1 <= hi1) ? C_TRACE1
               : (en1 && y1 > SPLIT && y1 >= lo2 && y1 <= hi2) ? C_TRACE2
               : 3'b000;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev1    <= '0;
            prev2    <= '0;
            rgb      <= '0;
            video_on <= 1'b0;
            pixel_x  <= '0;
            pixel_y  <= '0;
            h_sync   <= 1'b1;
            v_sync   <= 1'b1;
        end else begin
            prev1    <= vis1 ? c1 : prev1;
            prev2    <= vis1 ? c2 : prev2;
            rgb      <= vis1 ? colour : 3'b000;
            video_on <= vis1;
            pixel_x  <= x1;
            pixel_y  <= y1;
            h_sync   <= hs1;
            v_sync   <= vs1;
        end
    end

endmodule
